// File: rtl/frame_window_reader.sv
// frame_window_reader
// Reads the stored pupil-search window back from the frame buffer RAM in
// row-major order. It streams every pixel, tagged with its window coordinates
// and start/end-of-frame markers, to the downstream stage over valid/ready.
// Each iStart taken in IDLE produces one full pass followed by a one-cycle oDone.
module frame_window_reader #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 10,
  parameter int X_W    = 8,
  parameter int Y_W    = 7
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic              oMemRE,
  input  logic [DATA_W-1:0] iMemData,
  output logic [DATA_W-1:0] oPixel,
  output logic [X_W-1:0]    oPixX,
  output logic [Y_W-1:0]    oPixY,
  output logic              oSOF,
  output logic              oEOF,
  output logic              oValid,
  input  logic              iReady,
  output logic              oBusy,
  output logic              oDone
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One output buffer slot: pixel plus the tags that travel with it.
  typedef struct packed {
    logic [DATA_W-1:0] pix;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              sof;
    logic              eof;
  } entry_t;

  state_t            state_reg;
  state_t            state_next;

  // Read-side position; addr_reg tracks rx + H_RES*ry incrementally.
  logic [X_W-1:0]    rx_reg;
  logic [Y_W-1:0]    ry_reg;
  logic [ADDR_W-1:0] addr_reg;

  // Tags of the read whose data arrives on iMemData this cycle.
  logic              inflight_reg;
  logic [X_W-1:0]    fl_x_reg;
  logic [Y_W-1:0]    fl_y_reg;
  logic              fl_sof_reg;
  logic              fl_eof_reg;

  // Two-slot output FIFO bookkeeping.
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  entry_t            entry_q [2];
  entry_t            head;

  logic              mem_re;
  logic              last_addr;
  logic              start_pass;
  logic              push;
  logic              pop;
  logic              room;
  logic [2:0]        demand;

  assign last_addr  = (rx_reg == X_LAST) && (ry_reg == Y_LAST);
  assign start_pass = (state_reg == S_IDLE) && iStart;
  assign push       = inflight_reg;
  assign pop        = oValid && iReady;

  // Slots already committed after this cycle's pop; a new read may only be
  // issued while that leaves a free slot, so the FIFO can never overflow.
  assign demand = 3'(count_reg) + 3'(inflight_reg) - 3'(pop);
  assign room   = (demand < 3'd2);

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and read issue.
  always_comb begin
    state_next = state_reg;
    mem_re     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (iStart) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (room) begin
          mem_re = 1'b1;
          if (last_addr) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leave as soon as the FIFO empties this cycle, so oDone follows
        // the last transfer without an idle gap.
        if (!inflight_reg &&
            ((count_reg == 2'd0) || ((count_reg == 2'd1) && pop))) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Read-side counters: cleared at pass start, advanced per issued read,
  // parked on the last address so oMemAddr holds once reads stop.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rx_reg   <= '0;
      ry_reg   <= '0;
      addr_reg <= '0;
    end else if (start_pass) begin
      rx_reg   <= '0;
      ry_reg   <= '0;
      addr_reg <= '0;
    end else if (mem_re && !last_addr) begin
      addr_reg <= addr_reg + 1'b1;
      if (rx_reg == X_LAST) begin
        rx_reg <= '0;
        ry_reg <= ry_reg + 1'b1;
      end else begin
        rx_reg <= rx_reg + 1'b1;
      end
    end
  end

  // In-flight tag register: coordinates ride alongside the one-cycle RAM read.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      inflight_reg <= 1'b0;
      fl_x_reg     <= '0;
      fl_y_reg     <= '0;
      fl_sof_reg   <= 1'b0;
      fl_eof_reg   <= 1'b0;
    end else begin
      inflight_reg <= mem_re;
      if (mem_re) begin
        fl_x_reg   <= rx_reg;
        fl_y_reg   <= ry_reg;
        fl_sof_reg <= (rx_reg == '0) && (ry_reg == '0);
        fl_eof_reg <= last_addr;
      end
    end
  end

  // FIFO storage: each slot captures returning RAM data when it is the write target.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      entry_t entry_reg;

      // Capture pixel plus travelling tags into this slot.
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= {iMemData, fl_x_reg, fl_y_reg, fl_sof_reg, fl_eof_reg};
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Outputs come straight from registers; frame markers are gated by valid
  // so a stale head slot never shows a marker.
  assign head     = entry_q[rd_ptr_reg];
  assign oValid   = (count_reg != 2'd0);
  assign oPixel   = head.pix;
  assign oPixX    = head.x;
  assign oPixY    = head.y;
  assign oSOF     = oValid && head.sof;
  assign oEOF     = oValid && head.eof;
  assign oMemAddr = addr_reg;
  assign oMemRE   = mem_re;
  assign oBusy    = (state_reg != S_IDLE);
  assign oDone    = (state_reg == S_DONE);

endmodule
